// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: arbitrate, run one operation, hold the response.
// Define ALU_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (requester 0 wins).
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          req_valid_i,
  output logic [1:0]          req_ready_o,
  input  logic [7:0]          req_ctrl_i,
  input  logic [2*DATA_W-1:0] req_src1_i,
  input  logic [2*DATA_W-1:0] req_src2_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_id_o,
  output logic [DATA_W-1:0]   rsp_data_o,
  output logic                rsp_zero_o,
  output logic                rsp_err_o,
  output logic [3:0]          alu_ctrl_o,
  output logic [DATA_W-1:0]   alu_src1_o,
  output logic [DATA_W-1:0]   alu_src2_o,
  input  logic [DATA_W-1:0]   alu_result_i,
  input  logic                alu_zero_i
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state, state_nxt;
  logic                win;
  logic [1:0]          grant;
  logic                hs;
  logic [3:0]          win_ctrl;
  logic [DATA_W-1:0]   win_src1, win_src2;

`ifdef ALU_ARB_RR_EN
  // prio names the requester that wins when both are valid
  logic prio;

  always_comb begin
    win = ~req_valid_i[0];
    if (req_valid_i == 2'b11) win = prio;
  end
`else
  always_comb begin
    win = ~req_valid_i[0];
  end
`endif

  always_comb begin
    grant = 2'b00;
    if (state == IDLE && !rst_i) grant = req_valid_i & (win ? 2'b10 : 2'b01);
    hs       = |grant;
    win_ctrl = win ? req_ctrl_i[7:4] : req_ctrl_i[3:0];
    win_src1 = win ? req_src1_i[2*DATA_W-1:DATA_W] : req_src1_i[DATA_W-1:0];
    win_src2 = win ? req_src2_i[2*DATA_W-1:DATA_W] : req_src2_i[DATA_W-1:0];
  end

  assign req_ready_o = grant;
  assign rsp_valid_o = (state == RESP);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (hs) state_nxt = win_ctrl[3] ? RESP : EXEC;
      EXEC: state_nxt = RESP;
      RESP: if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU operand registers double as the capture of a legal request, so the ALU sees only legal codes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_id_o   <= 1'b0;
      rsp_data_o <= '0;
      rsp_zero_o <= 1'b0;
      rsp_err_o  <= 1'b0;
      alu_ctrl_o <= 4'b1111;
      alu_src1_o <= '0;
      alu_src2_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            rsp_id_o <= win;
            if (win_ctrl[3]) begin
              rsp_data_o <= '0;
              rsp_zero_o <= 1'b0;
              rsp_err_o  <= 1'b1;
            end else begin
              alu_ctrl_o <= win_ctrl;
              alu_src1_o <= win_src1;
              alu_src2_o <= win_src2;
            end
          end
        end
        EXEC: begin
          rsp_data_o <= alu_result_i;
          rsp_zero_o <= alu_zero_i;
          rsp_err_o  <= 1'b0;
          alu_ctrl_o <= 4'b1111;
          alu_src1_o <= '0;
          alu_src2_o <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_RR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)   prio <= 1'b0;
    else if (hs) prio <= ~win;
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a response scoreboard.
// Expected grant order follows ALU_ARB_RR_EN (round-robin) or its absence (fixed priority).
module tb_alu_arbiter;
  localparam int W = 32;

  logic           clk, rst;
  logic [1:0]     req_valid, req_ready;
  logic [7:0]     req_ctrl;
  logic [2*W-1:0] req_src1, req_src2;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [W-1:0]   rsp_data;
  logic [3:0]     alu_ctrl;
  logic [W-1:0]   alu_src1, alu_src2, alu_result;
  logic           alu_zero;

  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
    logic         zero;
    logic         err;
  } rsp_t;

  rsp_t       sb[$];
  rsp_t       mon_exp, mon_got;
  logic [3:0] mon_c;

  alu_arbiter #(.DATA_W(W)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_ctrl_i(req_ctrl),
    .req_src1_i(req_src1), .req_src2_i(req_src2),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_data_o(rsp_data), .rsp_zero_o(rsp_zero), .rsp_err_o(rsp_err),
    .alu_ctrl_o(alu_ctrl), .alu_src1_o(alu_src1), .alu_src2_o(alu_src2),
    .alu_result_i(alu_result), .alu_zero_i(alu_zero)
  );

  function automatic logic [W-1:0] alu_model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a ^ b;
      4'd4: return a << b[4:0];
      4'd5: return a >> b[4:0];
      4'd6: return a - b;
      4'd7: return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_model(alu_ctrl, alu_src1, alu_src2);
  assign alu_zero   = (alu_result == '0);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: push at each request handshake, pop at each response handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected: got response id=%0d data=%h err=%0d, required none", rsp_id, rsp_data, rsp_err);
        end else begin
          mon_exp = sb.pop_front();
          mon_got = '{id: rsp_id, data: rsp_data, zero: rsp_zero, err: rsp_err};
          if (mon_got !== mon_exp)
            $display("FAIL sb_rsp: got id=%0d data=%h zero=%0d err=%0d, required id=%0d data=%h zero=%0d err=%0d",
                     mon_got.id, mon_got.data, mon_got.zero, mon_got.err,
                     mon_exp.id, mon_exp.data, mon_exp.zero, mon_exp.err);
          else n_pass++;
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          mon_c = req_ctrl[4*k +: 4];
          mon_exp.id = k[0];
          if (mon_c[3]) begin
            mon_exp.data = '0;
            mon_exp.zero = 1'b0;
            mon_exp.err  = 1'b1;
          end else begin
            mon_exp.data = alu_model(mon_c, req_src1[W*k +: W], req_src2[W*k +: W]);
            mon_exp.zero = (mon_exp.data == '0);
            mon_exp.err  = 1'b0;
          end
          sb.push_back(mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    req_ctrl[4*k +: 4] = c;
    req_src1[W*k +: W] = a;
    req_src2[W*k +: W] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; req_ctrl = 8'h22; req_src1 = '1; req_src2 = '1; rsp_ready = 1'b0;
    tick(); tick();
    n_total++;
    if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b required 00", req_ready); else n_pass++;
    n_total++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err} !== '0)
      $display("FAIL reset_rsp: got v=%0d id=%0d d=%h z=%0d e=%0d required all 0", rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err);
    else n_pass++;
    n_total++;
    if ({alu_ctrl, alu_src1, alu_src2} !== {4'b1111, {(2*W){1'b0}}})
      $display("FAIL reset_alu: got ctrl=%b a=%h b=%h required 1111/0/0", alu_ctrl, alu_src1, alu_src2);
    else n_pass++;
    rst = 1'b0; req_valid = 2'b00;
    tick();
  endtask

  task automatic test_add();
    rsp_ready = 1'b1;
    set_req(0, 4'b0010, 5, 7);
    req_valid = 2'b01;
    #1;
    n_total++;
    if (req_ready !== 2'b01) $display("FAIL add_grant: got %b required 01", req_ready); else n_pass++;
    tick();
    req_valid = 2'b00;
    #1;
    n_total++;
    if ({alu_ctrl, alu_src1, alu_src2, rsp_valid} !== {4'b0010, 32'd5, 32'd7, 1'b0})
      $display("FAIL add_exec: got ctrl=%b a=%0d b=%0d v=%0d required 0010/5/7/0", alu_ctrl, alu_src1, alu_src2, rsp_valid);
    else n_pass++;
    tick();
    n_total++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, alu_ctrl} !== {1'b1, 1'b0, 32'd12, 1'b0, 1'b0, 4'b1111})
      $display("FAIL add_rsp: got v=%0d id=%0d d=%0d z=%0d e=%0d ctrl=%b required 1/0/12/0/0/1111",
               rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, alu_ctrl);
    else n_pass++;
    tick();
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL add_idle: got rsp_valid=%0d required 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_ops();
    int k;
    bit seen;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      k = i % 2;
      set_req(k, i[3:0], $urandom, (i == 6) ? req_src1[W*k +: W] : $urandom);
      req_valid = 2'b01 << k;
      #1;
      n_total++;
      if (req_ready !== (2'b01 << k)) $display("FAIL ops_grant: op %0d got %b required %b", i, req_ready, 2'b01 << k);
      else n_pass++;
      tick();
      req_valid = 2'b00;
      seen = 1'b0;
      for (int c = 0; c < 5 && !seen; c++) begin
        #1;
        if (rsp_valid) seen = 1'b1;
        tick();
      end
      n_total++;
      if (!seen) $display("FAIL ops_timeout: op %0d got no response, required one within 5 cycles", i); else n_pass++;
    end
  endtask

  task automatic test_illegal();
    rsp_ready = 1'b1;
    set_req(1, 4'b1111, 3, 4);
    req_valid = 2'b10;
    #1;
    n_total++;
    if ({req_ready, alu_ctrl} !== {2'b10, 4'b1111}) $display("FAIL ill_grant: got ready=%b ctrl=%b required 10/1111", req_ready, alu_ctrl);
    else n_pass++;
    tick();
    req_valid = 2'b00;
    #1;
    n_total++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data, alu_ctrl} !== {4'b1110, 32'd0, 4'b1111})
      $display("FAIL ill_rsp: got v=%0d id=%0d e=%0d z=%0d d=%h ctrl=%b required 1/1/1/0/0/1111",
               rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data, alu_ctrl);
    else n_pass++;
    tick();
    n_total++;
    if ({rsp_valid, alu_ctrl} !== {1'b0, 4'b1111}) $display("FAIL ill_after: got v=%0d ctrl=%b required 0/1111", rsp_valid, alu_ctrl);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    set_req(0, 4'b0110, 20, 20);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b11;
    set_req(0, 4'b0010, 1, 1);
    set_req(1, 4'b0010, 2, 2);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, req_ready} !== {1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 2'b00})
        $display("FAIL bp_hold: cycle %0d got v=%0d id=%0d d=%h z=%0d e=%0d ready=%b required 1/0/0/1/0/00",
                 i, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, req_ready);
      else n_pass++;
      req_src1[W-1:0] = $urandom;
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    req_valid = 2'b01;
    #1;
    n_total++;
    if ({rsp_valid, req_ready} !== {1'b0, 2'b01}) $display("FAIL bp_idle: got v=%0d ready=%b required 0/01", rsp_valid, req_ready);
    else n_pass++;
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_spacing();
    int hs_t[$];
    rsp_ready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      hs_t.delete();
      set_req(0, (pass == 0) ? 4'b1000 : 4'b0001, 32'h55, 32'haa);
      req_valid = 2'b01;
      for (int c = 0; c < 20 && hs_t.size() < 3; c++) begin
        #1;
        if (|(req_valid & req_ready)) hs_t.push_back(c);
        tick();
      end
      req_valid = 2'b00;
      n_total++;
      if (hs_t.size() != 3) $display("FAIL spacing_count: pass %0d got %0d handshakes required 3", pass, hs_t.size());
      else begin
        n_pass++;
        for (int i = 1; i < 3; i++) begin
          n_total++;
          if (hs_t[i] - hs_t[i-1] != ((pass == 0) ? 2 : 3))
            $display("FAIL spacing_gap: pass %0d got %0d cycles required %0d", pass, hs_t[i] - hs_t[i-1], (pass == 0) ? 2 : 3);
          else n_pass++;
        end
      end
      for (int c = 0; c < 4; c++) tick();
    end
  endtask

  task automatic test_arb();
    logic [1:0] grants[$];
    logic [1:0] want;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 4'b0010, 1, 2);
    set_req(1, 4'b0001, 10, 20);
    req_valid = 2'b11;
    for (int c = 0; c < 30 && grants.size() < 4; c++) begin
      #1;
      if (req_ready != 2'b00) grants.push_back(req_ready);
      tick();
    end
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      want = 2'b01;
`endif
      n_total++;
      if (i >= grants.size()) $display("FAIL arb_seq: grant %0d missing, required %b", i, want);
      else if (grants[i] !== want) $display("FAIL arb_seq: grant %0d got %b required %b", i, grants[i], want);
      else n_pass++;
    end
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_reset_mid();
    bit bad;
    rsp_ready = 1'b1;
    set_req(0, 4'b0010, 100, 200);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b11;
    rst = 1'b1;
    #1;
    n_total++;
    if ({alu_ctrl, req_ready} !== {4'b0010, 2'b00}) $display("FAIL rmid_exec: got ctrl=%b ready=%b required 0010/00", alu_ctrl, req_ready);
    else n_pass++;
    tick();
    rst = 1'b0;
    req_valid = 2'b00;
    #1;
    n_total++;
    if ({rsp_valid, alu_ctrl, alu_src1, alu_src2} !== {1'b0, 4'b1111, {(2*W){1'b0}}})
      $display("FAIL rmid_after: got v=%0d ctrl=%b a=%h b=%h required 0/1111/0/0", rsp_valid, alu_ctrl, alu_src1, alu_src2);
    else n_pass++;
    req_valid = 2'b10;
    set_req(1, 4'b1001, 0, 0);
    #1;
    n_total++;
    if (req_ready !== 2'b10) $display("FAIL rmid_idle: got ready=%b required 10", req_ready); else n_pass++;
    req_valid = 2'b00;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rsp_valid) bad = 1'b1;
    end
    n_total++;
    if (bad) $display("FAIL rmid_dropped: got a response for the dropped request, required none"); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_ctrl = '0; req_src1 = '0; req_src2 = '0; rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_ops();
    test_illegal();
    test_backpressure();
    test_spacing();
    test_arb();
    test_reset_mid();
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_drain: got %0d outstanding responses required 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 32, operand and result width.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with the ports listed in REQ-003 to REQ-020.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 req_valid_i  input  2  bit k = requester k (0 = pipeline EX, 1 = secondary unit) holds a valid request.
REQ-006 req_ready_o  output  2  bit k = request k accepted this cycle when req_valid_i[k] is also high.
REQ-007 req_ctrl_i  input  8  packed 4-bit ALU control code; [3:0] = requester 0, [7:4] = requester 1.
REQ-008 req_src1_i  input  2*DATA_W  packed operand A; low half = requester 0.
REQ-009 req_src2_i  input  2*DATA_W  packed operand B; low half = requester 0.
REQ-010 rsp_valid_o  output  1  response available.
REQ-011 rsp_ready_i  input  1  response consumer ready.
REQ-012 rsp_id_o  output  1  requester index of the response.
REQ-013 rsp_data_o  output  DATA_W  ALU result.
REQ-014 rsp_zero_o  output  1  ALU zero flag.
REQ-015 rsp_err_o  output  1  request carried an unsupported control code.
REQ-016 alu_ctrl_o  output  4  control code to the shared ALU.
REQ-017 alu_src1_o  output  DATA_W  operand A to the shared ALU.
REQ-018 alu_src2_o  output  DATA_W  operand B to the shared ALU.
REQ-019 alu_result_i  input  DATA_W  combinational ALU result.
REQ-020 alu_zero_i  input  1  combinational ALU zero flag.

Function
REQ-021 The block SHALL implement the FSM states IDLE, EXEC and RESP.
REQ-022 In IDLE, req_ready_o SHALL be one-hot on the arbitration winner among the valid requesters, and zero when no requester is valid.
REQ-023 In EXEC and RESP, req_ready_o SHALL be 2'b00; requests are not queued.
REQ-024 On a handshake (valid and ready), the block SHALL capture the winner's ctrl, src1, src2 and index.
REQ-025 The captured codes 4'b0000-4'b0111 SHALL be legal and move the FSM to EXEC; any code with bit 3 set SHALL be illegal and move the FSM directly to RESP.
REQ-026 In EXEC (exactly 1 cycle), alu_ctrl_o, alu_src1_o and alu_src2_o SHALL be registered copies of the captured values, stable for the whole cycle.
REQ-027 At the end of EXEC, the block SHALL register alu_result_i and alu_zero_i into rsp_data_o and rsp_zero_o, set rsp_err_o=0, and move to RESP.
REQ-028 Outside EXEC, alu_ctrl_o SHALL be 4'b1111 (no-op) and alu_src1_o and alu_src2_o SHALL be 0.
REQ-029 For an illegal code, the response SHALL be rsp_err_o=1, rsp_data_o=0, rsp_zero_o=0, and the ALU SHALL never be driven with that request.
REQ-030 In RESP, rsp_valid_o SHALL be 1 and all rsp_* outputs SHALL hold stable until rsp_ready_i=1; on that handshake the FSM SHALL return to IDLE.
REQ-031 Latency SHALL be: handshake in cycle N -> rsp_valid_o high in cycle N+2 (legal) or N+1 (illegal).
REQ-032 Minimum spacing between accepted requests SHALL be 3 cycles (legal) or 2 cycles (illegal).
REQ-033 rsp_valid_o SHALL be 0 in IDLE and EXEC.
REQ-034 Request inputs SHALL be ignored outside IDLE; changes to a requester's inputs while it is not granted SHALL have no effect.

Reset
REQ-035 rst_i SHALL take priority over all other events.
REQ-036 Reset SHALL force: FSM=IDLE, rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, rsp_zero_o=0, rsp_err_o=0, alu_ctrl_o=4'b1111, alu_src1_o=0, alu_src2_o=0, round-robin pointer favouring requester 0.
REQ-037 A reset asserted in EXEC or RESP SHALL drop the in-flight transaction with no response ever produced.
REQ-038 req_ready_o SHALL be 2'b00 in any cycle where rst_i=1.

Configuration
REQ-039 The macro ALU_ARB_RR_EN SHALL select the arbitration policy.
REQ-040 With ALU_ARB_RR_EN defined, arbitration SHALL be round-robin: on simultaneous requests the requester not most recently granted wins, and the pointer updates only on an accepted handshake.
REQ-041 Without ALU_ARB_RR_EN, arbitration SHALL be fixed priority with requester 0 always winning, and no pointer state shall exist.

Verification
REQ-042 Directed test, ADD: r0 ctrl=0010, src1=5, src2=7, ALU model returns 12, handshake at N -> alu_ctrl_o=0010 at N+1; rsp_valid=1, id=0, data=12, zero=0, err=0 at N+2.
REQ-043 Directed test, round-robin: both valid continuously, rsp_ready=1, ALU_ARB_RR_EN defined -> grant sequence 0,1,0,1.
REQ-044 Directed test, fixed priority: same stimulus as REQ-043 without ALU_ARB_RR_EN -> grant sequence 0,0,0,0.
REQ-045 Directed test, illegal code: r1 ctrl=1111 handshake at N -> rsp_valid=1, id=1, err=1, data=0 at N+1; alu_ctrl_o stays 1111 throughout.
REQ-046 Directed test, backpressure: rsp_ready=0 for 4 cycles in RESP -> rsp_* outputs unchanged and req_ready_o=00 for all 4 cycles; IDLE on the cycle after rsp_ready=1.
REQ-047 Directed test, reset mid-operation: rst_i pulsed during EXEC -> next cycle FSM=IDLE, rsp_valid=0, alu_ctrl_o=1111, and no response is ever produced for the dropped request.
